// File: rtl/alu_packet_ctrl_pkg.sv
// Shared types and constants for the UART-to-ALU packet sequencer.
// Opcodes 0x10..0x15 map onto alu_op_e through their low three bits.
package alu_packet_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    localparam logic [7:0] OPC_ADD = 8'h10;
    localparam logic [7:0] OPC_SUB = 8'h11;
    localparam logic [7:0] OPC_AND = 8'h12;
    localparam logic [7:0] OPC_OR  = 8'h13;
    localparam logic [7:0] OPC_XOR = 8'h14;
    localparam logic [7:0] OPC_MUL = 8'h15;

    localparam logic [15:0] HDR_BYTES = 16'd4;
    localparam logic [15:0] MIN_LEN   = 16'd8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR        = 3'd1,
        ST_LOAD_FIRST = 3'd2,
        ST_LOAD       = 3'd3,
        ST_RUN        = 3'd4,
        ST_TX         = 3'd5,
        ST_DRAIN      = 3'd6
    } state_e;

    function automatic logic opcode_known(input logic [7:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_MUL);
    endfunction

endpackage

// File: rtl/alu_packet_ctrl_byte_shift4.sv
// Little-endian 4-byte word assembler: the first byte received lands in word[7:0].
// word/last are combinational so the owner can capture the word on the 4th byte's cycle.
module byte_shift4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        last
);

    logic [23:0] sr_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (valid) begin
            sr_q  <= {data, sr_q[23:8]};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign word = {data, sr_q};
    assign last = valid && (cnt_q == 2'd3);

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer: parses framed UART requests, chains operands through the ALU,
// and streams the 32-bit accumulator back out little-endian.
// Handshakes: a byte moves on a cycle where valid && ready are both high; a producer
// holds valid and data stable until that cycle, and ready never depends on valid.
module alu_packet_ctrl
    import alu_packet_ctrl_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 5000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [2:0]           alu_op_o,
    output logic [DataWidth-1:0] alu_a_o,
    output logic [DataWidth-1:0] alu_b_o,
    output logic                 alu_start_o,
    input  logic                 alu_done_i,
    input  logic [DataWidth-1:0] alu_result_i,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    state_e               state_q, state_d;
    logic [7:0]           opc_q;
    logic [2:0]           op_q;
    logic [1:0]           hdr_cnt_q;
    logic [7:0]           len_lo_q;
    logic [15:0]          remaining_q;
    logic [DataWidth-1:0] acc_q, b_q;
    logic [1:0]           tx_idx_q;
    logic [TmoW-1:0]      tmo_q;
    logic                 start_q, start_d;

    logic        rx_fire, tx_fire, loading, tmo_active, tmo_hit;
    logic [15:0] len_w;
    logic [31:0] word;
    logic        word_last;

    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_o && tx_ready_i;
    assign len_w      = {rx_data_i, len_lo_q};
    assign loading    = (state_q == ST_LOAD_FIRST) || (state_q == ST_LOAD);
    assign tmo_active = loading || (state_q == ST_HDR) || (state_q == ST_DRAIN);
    assign tmo_hit    = tmo_active && !rx_fire && (tmo_q == TmoLast);

    byte_shift4 u_shift (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (!loading),
        .valid (rx_fire && loading),
        .data  (rx_data_i),
        .word  (word),
        .last  (word_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        rx_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_fire) state_d = ST_HDR;
            end
            ST_HDR: begin
                rx_ready_o = 1'b1;
                if (rx_fire && hdr_cnt_q == 2'd2) begin
                    if (len_w <= HDR_BYTES)
                        state_d = ST_IDLE;
                    else if (len_w < MIN_LEN || len_w[1:0] != 2'b00 || !opcode_known(opc_q))
                        state_d = ST_DRAIN;
                    else
                        state_d = ST_LOAD_FIRST;
                end
            end
            ST_LOAD_FIRST: begin
                rx_ready_o = 1'b1;
                if (word_last) state_d = (remaining_q == 16'd1) ? ST_TX : ST_LOAD;
            end
            ST_LOAD: begin
                rx_ready_o = 1'b1;
                if (word_last) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (alu_done_i) state_d = (remaining_q == 16'd0) ? ST_TX : ST_LOAD;
            end
            ST_TX: begin
                if (tx_fire && tx_idx_q == 2'd3) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                rx_ready_o = 1'b1;
                if (rx_fire && remaining_q == 16'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An idle gap in an open packet abandons it without any response.
        if (tmo_hit) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            opc_q       <= '0;
            op_q        <= '0;
            hdr_cnt_q   <= '0;
            len_lo_q    <= '0;
            remaining_q <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            tx_idx_q    <= '0;
            tmo_q       <= '0;
        end else begin
            tmo_q <= (!tmo_active || rx_fire) ? '0 : tmo_q + 1'b1;

            if (state_q == ST_IDLE && rx_fire) begin
                opc_q     <= rx_data_i;
                op_q      <= rx_data_i[2:0];
                hdr_cnt_q <= '0;
            end

            if (state_q == ST_HDR && rx_fire) begin
                hdr_cnt_q <= hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd1) len_lo_q <= rx_data_i;
                if (hdr_cnt_q == 2'd2)
                    remaining_q <= (len_w > HDR_BYTES) ? len_w - HDR_BYTES : 16'd0;
            end

            if ((loading || state_q == ST_DRAIN) && rx_fire)
                remaining_q <= remaining_q - 16'd1;

            if (state_q == ST_LOAD_FIRST && word_last) acc_q <= word;
            if (state_q == ST_LOAD && word_last)       b_q   <= word;
            if (state_q == ST_RUN && alu_done_i)       acc_q <= alu_result_i;

            if (state_q != ST_TX)  tx_idx_q <= '0;
            else if (tx_fire)      tx_idx_q <= tx_idx_q + 2'd1;
        end
    end

    assign tx_valid_o  = (state_q == ST_TX);
    assign tx_data_o   = tx_valid_o ? acc_q[8*tx_idx_q +: 8] : 8'h00;
    assign alu_op_o    = op_q;
    assign alu_a_o     = acc_q;
    assign alu_b_o     = b_q;
    assign alu_start_o = start_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Directed bench for alu_packet_ctrl; the bench plays both UART sides and the ALU.
module tb_alu_packet_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_start;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        busy;
    logic [2:0]  dbg_state;

    int passed = 0;
    int total  = 0;
    int start_count = 0;
    int tx_count = 0;

    alu_packet_ctrl #(.DataWidth(32), .TimeoutCycles(100)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_start_o  (alu_start),
        .alu_done_i   (alu_done),
        .alu_result_i (alu_result),
        .busy_o       (busy),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_start) start_count++;
        if (tx_valid && tx_ready) tx_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // driver tasks: every task returns 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] opc, input logic [15:0] len);
        send_byte(opc);
        send_byte(8'h00);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // waits for the start pulse, checks operands and that the pulse lasts one cycle
    task automatic expect_run(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(alu_start), 32'd1);
        check({tag, "_op"}, 32'(alu_op), 32'(op));
        check({tag, "_a"}, alu_a, a);
        check({tag, "_b"}, alu_b, b);
        @(negedge clk);
        check({tag, "_start_1cyc"}, 32'(alu_start), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_a_stable"}, alu_a, a);
        check({tag, "_b_stable"}, alu_b, b);
        @(posedge clk); #1;
    endtask

    task automatic alu_reply(input logic [31:0] r);
        alu_done   = 1'b1;
        alu_result = r;
        @(posedge clk); #1;
        alu_done   = 1'b0;
        alu_result = 32'h0;
    endtask

    task automatic expect_tx(input string tag, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            @(negedge clk);
            while (!tx_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_tx_valid"}, 32'(tx_valid), 32'd1);
            check({tag, "_tx_byte"}, 32'(tx_data), 32'(w[8*i +: 8]));
            @(posedge clk); #1;
        end
    endtask

    int s0, t0;
    logic held_ok;

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        alu_done = 1'b0; alu_result = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: ADD 5 + 7
        s0 = start_count;
        send_hdr(8'h10, 16'h000C);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send_word(32'd5);
        send_word(32'd7);
        expect_run("t1", 3'd0, 32'd5, 32'd7);
        alu_reply(32'd12);
        expect_tx("t1", 32'h0000000C);
        check("t1_one_start", 32'(start_count - s0), 32'd1);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 2: single operand, no ALU pass, one-cycle latency
        s0 = start_count;
        tx_ready = 1'b0;
        send_hdr(8'h12, 16'h0008);
        send_word(32'hDEADBEEF);
        @(negedge clk);
        check("t2_latency", 32'(tx_valid), 32'd1);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_tx("t2", 32'hDEADBEEF);
        check("t2_no_start", 32'(start_count - s0), 32'd0);

        // 3: SUB 100 - 30 - 20, tx stalled on the first byte
        send_hdr(8'h11, 16'h0010);
        send_word(32'd100);
        send_word(32'd30);
        expect_run("t3a", 3'd1, 32'd100, 32'd30);
        alu_reply(32'd70);
        check("t3_rx_reloads", 32'(rx_ready), 32'd1);
        send_word(32'd20);
        expect_run("t3b", 3'd1, 32'd70, 32'd20);
        tx_ready = 1'b0;
        alu_reply(32'd50);
        t0 = tx_count;
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h32)) held_ok = 1'b0;
        end
        check("t3_held_stable", 32'(held_ok), 32'd1);
        check("t3_no_xfer_held", 32'(tx_count - t0), 32'd0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_tx("t3", 32'h00000032);

        // 4: unknown opcode drained, then XOR packet
        t0 = tx_count;
        s0 = start_count;
        send_hdr(8'h7F, 16'h000C);
        @(negedge clk);
        check("t4_drain_state", 32'(dbg_state), 32'd6);
        @(posedge clk); #1;
        send_word(32'h11223344);
        send_word(32'h55667788);
        @(negedge clk);
        check("t4_drain_idle", 32'(busy), 32'd0);
        check("t4_no_tx", 32'(tx_count - t0), 32'd0);
        check("t4_no_start", 32'(start_count - s0), 32'd0);
        @(posedge clk); #1;
        send_hdr(8'h14, 16'h000C);
        send_word(32'hF0F0F0F0);
        send_word(32'hFF00FF00);
        expect_run("t4", 3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
        alu_reply(32'h0FF00FF0);
        expect_tx("t4", 32'h0FF00FF0);

        // 4b: len == 4 closes the packet on the last header byte
        send_hdr(8'h10, 16'h0004);
        @(negedge clk);
        check("t4b_len4_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 5: timeout after a partial operand
        t0 = tx_count;
        send_hdr(8'h10, 16'h000C);
        send_byte(8'h01);
        repeat (98) @(posedge clk);
        @(negedge clk);
        check("t5_before_timeout", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_after_timeout", 32'(busy), 32'd0);
        check("t5_no_tx", 32'(tx_count - t0), 32'd0);
        @(posedge clk); #1;

        // 6: reset during RUN
        t0 = tx_count;
        send_hdr(8'h11, 16'h000C);
        send_word(32'd9);
        send_word(32'd4);
        expect_run("t6", 3'd1, 32'd9, 32'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rx_ready", 32'(rx_ready), 32'd1);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        check("t6_tx_data", 32'(tx_data), 32'd0);
        check("t6_start", 32'(alu_start), 32'd0);
        check("t6_op", 32'(alu_op), 32'd0);
        check("t6_a", alu_a, 32'd0);
        check("t6_b", alu_b, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        alu_reply(32'hDEAD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_late_done_busy", 32'(busy), 32'd0);
        check("t6_late_done_a", alu_a, 32'd0);
        check("t6_late_done_tx", 32'(tx_count - t0), 32'd0);
        @(posedge clk); #1;

        // recovery after reset
        send_hdr(8'h10, 16'h0008);
        send_word(32'h0000002A);
        expect_tx("t7", 32'h0000002A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
